led_pwm_gpio: RTL and testbench

LED_PWM_GPIO -- requirements
Module: led_pwm_gpio

---
 rtl/led_pwm_pkg.sv | 48 ++++
 rtl/led_pwm_timebase.sv | 40 ++++
 rtl/led_pwm_gpio.sv | 111 +++++++++++
 tb/tb_led_pwm_gpio.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared register map, CTRL bit positions and reset values for the LED PWM/GPIO peripheral.
package led_pwm_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_DIRECT = 8'h04;
    localparam logic [7:0] ADDR_DUTY0  = 8'h08;
    localparam logic [7:0] ADDR_DUTY1  = 8'h0C;
    localparam logic [7:0] ADDR_STATUS = 8'h10;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;

    localparam logic [1:0]  CTRL_RST   = 2'b00;
    localparam logic [7:0]  DIRECT_RST = 8'h00;
    localparam logic [31:0] DUTY_RST   = 32'h0000_0000;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_DIRECT,
        REG_DUTY0,
        REG_DUTY1,
        REG_STATUS,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [7:0] off);
        case (off)
            ADDR_CTRL:   return REG_CTRL;
            ADDR_DIRECT: return REG_DIRECT;
            ADDR_DUTY0:  return REG_DUTY0;
            ADDR_DUTY1:  return REG_DUTY1;
            ADDR_STATUS: return REG_STATUS;
            default:     return REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler divides clk down to phase steps; tick marks each step.
module led_pwm_timebase #(
    parameter int PRESCALE = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    output logic       tick,
    output logic [7:0] phase
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_reg;
    logic          wrap;

    assign wrap = (presc_reg == PW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_reg <= '0;
            phase     <= 8'd0;
            tick      <= 1'b0;
        end else if (!en) begin
            presc_reg <= '0;
            phase     <= 8'd0;
            tick      <= 1'b0;
        end else begin
            // tick is registered so it is high in the same cycle as the new phase
            tick <= wrap;
            if (wrap) begin
                presc_reg <= '0;
                phase     <= phase + 8'd1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_pwm_gpio.sv
// Memory-mapped 8-LED driver: direct GPIO mode or 8-bit PWM with per-period duty shadowing.
module led_pwm_gpio
    import led_pwm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESCALE  = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [7:0]  led
);

    logic [1:0]       ctrl_reg, ctrl_next;
    logic [7:0]       direct_reg, direct_next;
    logic [31:0]      duty0_reg, duty0_next;
    logic [31:0]      duty1_reg, duty1_next;
    logic [7:0][7:0]  active_reg, active_next;
    logic [7:0][7:0]  duty_all;
    logic [7:0]       pwm_bits, led_next;
    logic [31:0]      rdata_next;
    logic             sel, wr, en, mode, tick, active_load;
    logic [7:0]       phase;
    reg_sel_e         rsel;

    assign sel  = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]) && !mem_ready;
    assign wr   = sel && (mem_wstrb != 4'b0000);
    assign rsel = decode_offset(mem_addr[7:0]);
    assign en   = ctrl_reg[CTRL_EN];
    assign mode = ctrl_reg[CTRL_MODE];

    led_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .tick   (tick),
        .phase  (phase)
    );

    always_comb begin
        ctrl_next   = ctrl_reg;
        direct_next = direct_reg;
        duty0_next  = duty0_reg;
        duty1_next  = duty1_reg;
        if (wr) begin
            case (rsel)
                REG_CTRL:   if (mem_wstrb[0]) ctrl_next = mem_wdata[1:0];
                REG_DIRECT: if (mem_wstrb[0]) direct_next = mem_wdata[7:0];
                REG_DUTY0:  duty0_next = apply_wstrb(duty0_reg, mem_wdata, mem_wstrb);
                REG_DUTY1:  duty1_next = apply_wstrb(duty1_reg, mem_wdata, mem_wstrb);
                default:    ;
            endcase
        end
    end

    always_comb begin
        rdata_next = 32'd0;
        case (rsel)
            REG_CTRL:   rdata_next = {30'd0, ctrl_reg};
            REG_DIRECT: rdata_next = {24'd0, direct_reg};
            REG_DUTY0:  rdata_next = duty0_reg;
            REG_DUTY1:  rdata_next = duty1_reg;
            REG_STATUS: rdata_next = {23'd0, tick, phase};
            default:    rdata_next = 32'd0;
        endcase
    end

    // Using the post-write duty lets a write that lands on the wrap tick take effect at once.
    assign duty_all    = {duty1_next, duty0_next};
    assign active_load = !en || (tick && (phase == 8'd0));

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_led
            assign active_next[gi] = active_load ? duty_all[gi] : active_reg[gi];
            assign pwm_bits[gi]    = (phase < active_next[gi]);
        end
    endgenerate

    always_comb begin
        led_next = 8'd0;
        if (en) led_next = mode ? pwm_bits : direct_reg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctrl_reg   <= CTRL_RST;
            direct_reg <= DIRECT_RST;
            duty0_reg  <= DUTY_RST;
            duty1_reg  <= DUTY_RST;
            active_reg <= '0;
            led        <= 8'd0;
            mem_ready  <= 1'b0;
            mem_rdata  <= 32'd0;
        end else begin
            ctrl_reg   <= ctrl_next;
            direct_reg <= direct_next;
            duty0_reg  <= duty0_next;
            duty1_reg  <= duty1_next;
            active_reg <= active_next;
            led        <= led_next;
            mem_ready  <= sel;
            mem_rdata  <= sel ? rdata_next : 32'd0;
        end
    end

endmodule

// File: tb/tb_led_pwm_gpio.sv
// Directed bench for led_pwm_gpio: register table plus PWM, shadowing, reset and bus sequences.
module tb_led_pwm_gpio;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  led;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pwm_gpio #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .led       (led)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Returns #1 into the mem_ready cycle (or after a 4-cycle timeout).
    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic got, output logic [31:0] rd);
        got = 1'b0;
        rd  = 32'd0;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                got = 1'b1;
                rd  = mem_rdata;
            end
        end
        mem_valid = 1'b0; mem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic        got;
        logic [31:0] rd;
        bus(BASE | {24'd0, off}, d, 4'hF, got, rd);
        check("wr_ready", {31'd0, got}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        logic [31:0] rd;
        int          cnt0, cnt1, cnt4;
        int          per [2];

        tbl[0]  = '{BASE | 32'h00, 32'h0,          4'h0, 1'b1, 32'h0};
        tbl[1]  = '{BASE | 32'h04, 32'h0,          4'h0, 1'b1, 32'h0};
        tbl[2]  = '{BASE | 32'h08, 32'h0,          4'h0, 1'b1, 32'h0};
        tbl[3]  = '{BASE | 32'h0C, 32'h0,          4'h0, 1'b1, 32'h0};
        tbl[4]  = '{BASE | 32'h10, 32'h0,          4'h0, 1'b1, 32'h0};
        tbl[5]  = '{BASE | 32'h08, 32'h1122_3344,  4'b0100, 1'b1, 32'h0};
        tbl[6]  = '{BASE | 32'h08, 32'h0,          4'h0, 1'b1, 32'h0022_0000};
        tbl[7]  = '{BASE | 32'h0C, 32'hDEAD_BEEF,  4'b1001, 1'b1, 32'h0};
        tbl[8]  = '{BASE | 32'h0C, 32'h0,          4'h0, 1'b1, 32'hDE00_00EF};
        tbl[9]  = '{BASE | 32'h04, 32'hFFFF_FF5A,  4'hF, 1'b1, 32'h0};
        tbl[10] = '{BASE | 32'h04, 32'h0,          4'h0, 1'b1, 32'h0000_005A};
        tbl[11] = '{BASE | 32'h10, 32'hFFFF_FFFF,  4'hF, 1'b1, 32'h0};
        tbl[12] = '{BASE | 32'h10, 32'h0,          4'h0, 1'b1, 32'h0};
        tbl[13] = '{BASE | 32'h20, 32'hFFFF_FFFF,  4'hF, 1'b1, 32'h0};
        tbl[14] = '{BASE | 32'h20, 32'h0,          4'h0, 1'b1, 32'h0};
        tbl[15] = '{32'h0300_0004, 32'h0,          4'h0, 1'b0, 32'h0};
        tbl[16] = '{BASE | 32'h00, 32'hFFFF_FFFF,  4'b1110, 1'b1, 32'h0};
        tbl[17] = '{BASE | 32'h00, 32'h0,          4'h0, 1'b1, 32'h0};
        tbl[18] = '{BASE | 32'h00, 32'hFFFF_FFF2,  4'b0001, 1'b1, 32'h0};
        tbl[19] = '{BASE | 32'h00, 32'h0,          4'h0, 1'b1, 32'h0000_0002};
        tbl[20] = '{BASE | 32'h00, 32'h0,          4'hF, 1'b1, 32'h0};

        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        #2;
        check("rst_led", {24'd0, led}, 32'h0);
        check("rst_ready", {31'd0, mem_ready}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Direct mode
        wr(8'h00, 32'h1);
        wr(8'h04, 32'hA5);
        check("direct_led_at_ready", {24'd0, led}, 32'h0);
        @(posedge clk); #1;
        check("direct_led", {24'd0, led}, 32'hA5);
        bus(BASE | 32'h04, 32'h0, 4'h0, got, rd);
        check("direct_rd", rd, 32'h0000_00A5);

        // Reset in the middle of a write
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = BASE | 32'h04; mem_wdata = 32'h3C; mem_wstrb = 4'hF;
        #3 resetn = 1'b0;
        #1;
        check("midrst_led", {24'd0, led}, 32'h0);
        check("midrst_ready", {31'd0, mem_ready}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("midrst_ready_hold", {31'd0, mem_ready}, 32'h0);
        end
        mem_valid = 1'b0; mem_wstrb = 4'd0;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("postrst_ready", {31'd0, mem_ready}, 32'h0);

        // Register table
        for (int i = 0; i < 21; i++) begin
            bus(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, got, rd);
            check($sformatf("tbl%0d_ready", i), {31'd0, got}, {31'd0, tbl[i].exp_ready});
            if (tbl[i].wstrb == 4'd0 && tbl[i].exp_ready)
                check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        end

        // One full PWM period
        wr(8'h08, 32'h0000_00FF);
        wr(8'h0C, 32'h0000_0040);
        wr(8'h00, 32'h3);
        cnt0 = 0; cnt1 = 0; cnt4 = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            cnt0 += int'(led[0]);
            cnt1 += int'(led[1]);
            cnt4 += int'(led[4]);
        end
        check("pwm_led0_high", cnt0, 255);
        check("pwm_led4_high", cnt4, 64);
        check("pwm_led1_high", cnt1, 0);

        // Duty change mid-period takes effect on the next period only
        wr(8'h00, 32'h0);
        wr(8'h0C, 32'h0000_0040);
        wr(8'h00, 32'h3);
        per[0] = 0; per[1] = 0;
        for (int k = 1; k <= 512; k++) begin
            @(posedge clk); #1;
            per[(k - 1) / 256] += int'(led[4]);
            if (k == 100) begin
                mem_valid = 1'b1; mem_addr = BASE | 32'h0C; mem_wdata = 32'h80; mem_wstrb = 4'hF;
            end
            if (k == 101) begin
                check("shadow_wr_ready", {31'd0, mem_ready}, 32'h1);
                mem_valid = 1'b0; mem_wstrb = 4'd0;
            end
        end
        check("shadow_period1", per[0], 64);
        check("shadow_period2", per[1], 128);

        // Back-to-back with mem_valid held high
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            mem_valid = 1'b1; mem_wstrb = 4'd0; mem_wdata = 32'hFFFF_FFFF;
            mem_addr  = (i < 4) ? (BASE | 32'h20) : (BASE | 32'h04);
            check($sformatf("b2b%0d_ready", i), {31'd0, mem_ready}, {31'd0, 1'(i % 2)});
            check($sformatf("b2b%0d_rdata", i), mem_rdata, (i == 5 || i == 7) ? 32'h5A : 32'h0);
        end
        mem_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_ready", {31'd0, mem_ready}, 32'h0);

        // Disable forces LEDs off
        wr(8'h00, 32'h0);
        @(posedge clk); #1;
        check("disable_led", {24'd0, led}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
